// File: rtl/ofm_pingpong_packer.sv
// rtl/ofm_pingpong_packer.sv - packs scalar results into wide beats through ping-pong BRAM banks
module ofm_pingpong_packer #(
    parameter int DATA_W     = 16,
    parameter int AXI_DATA_W = 128,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [AXI_DATA_W-1:0]   out_data,
    output logic [AXI_DATA_W/8-1:0] out_strb,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              bank_full,
    output logic                    trunc_err,
    input  logic                    clear_err
);
    localparam int PF  = AXI_DATA_W / DATA_W;
    localparam int EW  = (PF > 1) ? $clog2(PF) : 1;
    localparam int LW  = $clog2(PF + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = AXI_DATA_W / 8;
    localparam int BPE = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} rd_state_t;

    logic [AXI_DATA_W-1:0] mem [2*DEPTH];

    logic                  wr_bank;
    logic [EW-1:0]         elem_idx;
    logic [AW-1:0]         word_ptr;
    logic [AXI_DATA_W-1:0] pack;
    logic [AXI_DATA_W-1:0] wr_word;
    logic [AW:0]           nwords [2];
    logic [LW-1:0]         last_elems [2];
    logic                  accept, commit, force_close, tile_close;

    assign in_ready    = !bank_full[wr_bank];
    assign accept      = in_valid && in_ready;
    assign commit      = accept && ((elem_idx == EW'(PF - 1)) || in_last);
    assign force_close = commit && !in_last && (word_ptr == AW'(DEPTH - 1));
    assign tile_close  = (accept && in_last) || force_close;

    // Slots above elem_idx are already zero because pack clears on every commit.
    always_comb begin
        wr_word = pack;
        for (int k = 0; k < PF; k++) begin
            if (elem_idx == EW'(k)) wr_word[k*DATA_W +: DATA_W] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[{wr_bank, word_ptr}] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank       <= 1'b0;
            elem_idx      <= '0;
            word_ptr      <= '0;
            pack          <= '0;
            trunc_err     <= 1'b0;
            nwords[0]     <= '0;
            nwords[1]     <= '0;
            last_elems[0] <= '0;
            last_elems[1] <= '0;
        end else begin
            if (tile_close) begin
                nwords[wr_bank]     <= (AW+1)'(word_ptr) + (AW+1)'(1);
                last_elems[wr_bank] <= LW'(elem_idx) + LW'(1);
                wr_bank             <= ~wr_bank;
                elem_idx            <= '0;
                word_ptr            <= '0;
                pack                <= '0;
            end else if (commit) begin
                elem_idx <= '0;
                word_ptr <= word_ptr + AW'(1);
                pack     <= '0;
            end else if (accept) begin
                elem_idx <= elem_idx + EW'(1);
                pack     <= wr_word;
            end
            if (force_close)    trunc_err <= 1'b1;
            else if (clear_err) trunc_err <= 1'b0;
        end
    end

    rd_state_t             state, state_nxt;
    logic                  rd_bank;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           cur_nw;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rd_pend, pend_last;
    logic [SW-1:0]         pend_strb;
    logic                  rd_issue, issue_last, room, pop, release_bank;
    logic [SW-1:0]         last_mask, issue_strb;
    logic [AXI_DATA_W-1:0] q_data [2];
    logic [SW-1:0]         q_strb [2];
    logic [1:0]            q_last;
    logic                  q_head;
    logic [1:0]            q_count;

    assign out_valid    = (q_count != 2'd0);
    assign out_data     = q_data[q_head];
    assign out_strb     = q_strb[q_head];
    assign out_last     = q_last[q_head];
    assign pop          = out_valid && out_ready;
    assign release_bank = pop && out_last;
    assign cur_nw       = nwords[rd_bank];
    assign issue_last   = (rd_ptr == cur_nw - (AW+1)'(1));
    // Queue entries plus the read in flight must never exceed the two skid slots.
    assign room         = ({1'b0, q_count} + 3'(rd_pend)) < (3'd2 + 3'(pop));

    always_comb begin
        for (int b = 0; b < SW; b++) begin
            last_mask[b] = (b < int'(last_elems[rd_bank]) * BPE);
        end
        issue_strb = issue_last ? last_mask : {SW{1'b1}};
    end

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_issue  = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_ptr == cur_nw) state_nxt = S_DONE;
                else if (room)        rd_issue  = 1'b1;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (release_bank) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rd_issue) rdata <= mem[{rd_bank, rd_ptr[AW-1:0]}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            pend_strb <= '0;
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_strb[0] <= '0;
            q_strb[1] <= '0;
            q_last    <= '0;
            q_head    <= 1'b0;
            q_count   <= '0;
            bank_full <= 2'b00;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_issue;
            if (release_bank) begin
                rd_bank <= ~rd_bank;
                rd_ptr  <= '0;
            end else if (rd_issue) begin
                rd_ptr  <= rd_ptr + (AW+1)'(1);
            end
            if (rd_issue) begin
                pend_last <= issue_last;
                pend_strb <= issue_strb;
            end
            if (rd_pend) begin
                q_data[q_head ^ q_count[0]] <= rdata;
                q_strb[q_head ^ q_count[0]] <= pend_strb;
                q_last[q_head ^ q_count[0]] <= pend_last;
            end
            q_head  <= q_head ^ pop;
            q_count <= q_count + 2'(rd_pend) - 2'(pop);
            if (tile_close)   bank_full[wr_bank] <= 1'b1;
            if (release_bank) bank_full[rd_bank] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ofm_pingpong_packer.sv
// tb/tb_ofm_pingpong_packer.sv - directed bench for ofm_pingpong_packer at DEPTH 256 and DEPTH 4
module tb_ofm_pingpong_packer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         clear_err = 1'b0;

    logic         rdy, vld, lst, trunc;
    logic [127:0] dat;
    logic [15:0]  stb;
    logic [1:0]   bf;
    logic         rdy4, vld4, lst4, trunc4;
    logic [127:0] dat4;
    logic [15:0]  stb4;
    logic [1:0]   bf4;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
    } beat_t;

    beat_t        q0[$];
    beat_t        q1[$];
    int           total = 0;
    int           bad = 0;
    int           hold_viol = 0;
    logic         stall0 = 1'b0;
    logic [127:0] hd;
    logic [15:0]  hs;
    logic         hl;

    always #5 clk = ~clk;

    ofm_pingpong_packer #(.DATA_W(16), .AXI_DATA_W(128), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy),
        .in_last(in_last), .out_data(dat), .out_strb(stb), .out_last(lst), .out_valid(vld),
        .out_ready(out_ready), .bank_full(bf), .trunc_err(trunc), .clear_err(clear_err)
    );

    ofm_pingpong_packer #(.DATA_W(16), .AXI_DATA_W(128), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
        .in_last(in_last), .out_data(dat4), .out_strb(stb4), .out_last(lst4), .out_valid(vld4),
        .out_ready(out_ready), .bank_full(bf4), .trunc_err(trunc4), .clear_err(clear_err)
    );

    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 = 1'b0;
        end else begin
            if (stall0 && (dat !== hd || stb !== hs || lst !== hl)) hold_viol++;
            if (vld && out_ready) q0.push_back('{dat, stb, lst});
            if (vld4 && out_ready) q1.push_back('{dat4, stb4, lst4});
            stall0 = vld && !out_ready;
            hd = dat;
            hs = stb;
            hl = lst;
        end
    end

    function automatic logic [127:0] mkw(input int first, input int n);
        logic [127:0] w = '0;
        for (int k = 0; k < n; k++) w[k*16 +: 16] = 16'(first + k);
        return w;
    endfunction

    task automatic send(input bit s4, input int d, input bit l);
        int n = 0;
        in_data  = 16'(d);
        in_valid = 1'b1;
        in_last  = l;
        while (((s4 ? rdy4 : rdy) !== 1'b1) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed low, element %0h not accepted", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_beats(input bit s4, input int n);
        int c = 0;
        while ((s4 ? q1.size() : q0.size()) < n && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if ((s4 ? q1.size() : q0.size()) != n) begin
            bad++;
            $display("FAIL beat_count: got %0d want %0d", (s4 ? q1.size() : q0.size()), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (vld !== 1'b0)    begin bad++; $display("FAIL rst_out_valid: got %b want 0", vld); end
        total++; if (lst !== 1'b0)    begin bad++; $display("FAIL rst_out_last: got %b want 0", lst); end
        total++; if (dat !== '0)      begin bad++; $display("FAIL rst_out_data: got %h want 0", dat); end
        total++; if (stb !== '0)      begin bad++; $display("FAIL rst_out_strb: got %h want 0", stb); end
        total++; if (bf !== 2'b00)    begin bad++; $display("FAIL rst_bank_full: got %b want 00", bf); end
        total++; if (trunc !== 1'b0)  begin bad++; $display("FAIL rst_trunc_err: got %b want 0", trunc); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (rdy !== 1'b1)    begin bad++; $display("FAIL rst_in_ready: got %b want 1", rdy); end
    endtask

    task automatic test_full_tile();
        q0.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) send(0, i, i == 16);
        idle_in();
        wait_beats(0, 2);
        if (q0.size() == 2) begin
            total++;
            if (q0[0].d !== 128'h0008_0007_0006_0005_0004_0003_0002_0001 || q0[0].s !== 16'hFFFF || q0[0].l !== 1'b0) begin
                bad++; $display("FAIL full_beat0: got %h/%h/%b want 0008..0001/ffff/0", q0[0].d, q0[0].s, q0[0].l);
            end
            total++;
            if (q0[1].d !== 128'h0010_000F_000E_000D_000C_000B_000A_0009 || q0[1].s !== 16'hFFFF || q0[1].l !== 1'b1) begin
                bad++; $display("FAIL full_beat1: got %h/%h/%b want 0010..0009/ffff/1", q0[1].d, q0[1].s, q0[1].l);
            end
        end
        total++; if (bf !== 2'b00) begin bad++; $display("FAIL full_bank_full: got %b want 00", bf); end
    endtask

    task automatic test_partial();
        q0.delete();
        for (int i = 1; i <= 11; i++) send(0, i, i == 11);
        idle_in();
        wait_beats(0, 2);
        if (q0.size() == 2) begin
            total++;
            if (q0[0].d !== 128'h0008_0007_0006_0005_0004_0003_0002_0001 || q0[0].s !== 16'hFFFF || q0[0].l !== 1'b0) begin
                bad++; $display("FAIL partial_beat0: got %h/%h/%b", q0[0].d, q0[0].s, q0[0].l);
            end
            total++;
            if (q0[1].d !== 128'h000B_000A_0009 || q0[1].s !== 16'h003F || q0[1].l !== 1'b1) begin
                bad++; $display("FAIL partial_beat1: got %h/%h/%b want 000b000a0009/003f/1", q0[1].d, q0[1].s, q0[1].l);
            end
        end
    endtask

    task automatic test_single();
        q0.delete();
        out_ready = 1'b0;
        send(0, 16'hABCD, 1'b1);
        idle_in();
        total++; if (bf !== 2'b01) begin bad++; $display("FAIL single_bank_full: got %b want 01", bf); end
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL single_lat0: out_valid got %b want 0", vld); end
        @(posedge clk); #1;
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL single_lat1: out_valid got %b want 0", vld); end
        @(posedge clk); #1;
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL single_lat2: out_valid got %b want 1", vld); end
        out_ready = 1'b1;
        wait_beats(0, 1);
        if (q0.size() == 1) begin
            total++;
            if (q0[0].d !== 128'hABCD || q0[0].s !== 16'h0003 || q0[0].l !== 1'b1) begin
                bad++; $display("FAIL single_beat: got %h/%h/%b want abcd/0003/1", q0[0].d, q0[0].s, q0[0].l);
            end
        end
    endtask

    task automatic test_back_to_back();
        q0.delete();
        hold_viol = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 16'h0100 + i, i == 7);
        for (int i = 0; i < 8; i++) send(0, 16'h0200 + i, i == 7);
        total++; if (bf !== 2'b11)  begin bad++; $display("FAIL bp_bank_full: got %b want 11", bf); end
        total++; if (rdy !== 1'b0)  begin bad++; $display("FAIL bp_in_ready: got %b want 0", rdy); end
        in_data  = 16'h0300;
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (rdy !== 1'b0 || q0.size() != 0) begin
            bad++; $display("FAIL bp_stalled: in_ready %b beats %0d want 0 and 0", rdy, q0.size());
        end
        total++; if (vld !== 1'b1 || dat !== mkw(16'h0100, 8)) begin
            bad++; $display("FAIL bp_held_beat: valid %b data %h want 1 and tile A", vld, dat);
        end
        fork
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send(0, 16'h0300 + i, i == 7);
                idle_in();
            end
        join
        wait_beats(0, 3);
        if (q0.size() == 3) begin
            for (int t = 0; t < 3; t++) begin
                total++;
                if (q0[t].d !== mkw(16'h0100 * (t + 1), 8) || q0[t].s !== 16'hFFFF || q0[t].l !== 1'b1) begin
                    bad++; $display("FAIL bp_order_tile%0d: got %h/%h/%b", t, q0[t].d, q0[t].s, q0[t].l);
                end
            end
        end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL bp_hold: %0d changes while stalled want 0", hold_viol); end
        total++; if (bf !== 2'b00)   begin bad++; $display("FAIL bp_drained: bank_full %b want 00", bf); end
    endtask

    task automatic test_trunc();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q1.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            send(1, i, i == 40);
            if (i == 31) begin
                total++; if (trunc4 !== 1'b0) begin bad++; $display("FAIL trunc_early: got %b want 0", trunc4); end
            end
            if (i == 32) begin
                total++; if (trunc4 !== 1'b1) begin bad++; $display("FAIL trunc_set: got %b want 1", trunc4); end
            end
        end
        idle_in();
        wait_beats(1, 5);
        if (q1.size() == 5) begin
            for (int b = 0; b < 5; b++) begin
                total++;
                if (q1[b].d !== mkw(1 + 8 * b, 8) || q1[b].s !== 16'hFFFF || q1[b].l !== (b == 3 || b == 4)) begin
                    bad++; $display("FAIL trunc_beat%0d: got %h/%h/%b", b, q1[b].d, q1[b].s, q1[b].l);
                end
            end
        end
        total++; if (trunc4 !== 1'b1) begin bad++; $display("FAIL trunc_sticky: got %b want 1", trunc4); end
        total++; if (bf4 !== 2'b00)   begin bad++; $display("FAIL trunc_bank_full: got %b want 00", bf4); end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        total++; if (trunc4 !== 1'b0) begin bad++; $display("FAIL trunc_clear: got %b want 0", trunc4); end
    endtask

    task automatic test_reset_mid_drain();
        int c = 0;
        q0.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(0, 16'h0400 + i, i == 31);
        idle_in();
        while (vld !== 1'b1 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b want 1", vld); end
        out_ready = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++; if (vld !== 1'b0 || lst !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: valid %b last %b want 0 0", vld, lst); end
        total++; if (dat !== '0 || stb !== '0)     begin bad++; $display("FAIL mid_rst_data: data %h strb %h want 0 0", dat, stb); end
        total++; if (bf !== 2'b00)                 begin bad++; $display("FAIL mid_rst_bank_full: got %b want 00", bf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete();
        for (int i = 0; i < 8; i++) send(0, 16'h0500 + i, i == 7);
        idle_in();
        wait_beats(0, 1);
        if (q0.size() == 1) begin
            total++;
            if (q0[0].d !== mkw(16'h0500, 8) || q0[0].s !== 16'hFFFF || q0[0].l !== 1'b1) begin
                bad++; $display("FAIL mid_after_beat: got %h/%h/%b", q0[0].d, q0[0].s, q0[0].l);
            end
        end
        total++; if (bf !== 2'b00) begin bad++; $display("FAIL mid_after_bank_full: got %b want 00", bf); end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_partial();
        test_single();
        test_back_to_back();
        test_trunc();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
